// File: rtl/master_port_if.sv
// Client request/response channel plus bit-serial master/slave bus of master_port.
// The master modport is the port's own view; slave is the view of client and serial slave.
interface master_port_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_mode;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  mode;
    logic                  wr_bus;
    logic                  master_valid;
    logic                  master_ready;
    logic                  rd_bus;
    logic                  slave_ready;
    logic                  slave_valid;

    modport master (
        input  req_valid, req_mode, req_addr, req_wdata, rd_bus, slave_ready, slave_valid,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mode, wr_bus, master_valid, master_ready
    );

    modport slave (
        output req_valid, req_mode, req_addr, req_wdata, rd_bus, slave_ready, slave_valid,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mode, wr_bus, master_valid, master_ready
    );
endinterface

// File: rtl/master_port.sv
// Serial bus master: sends address then data MSB first, collects read data, and
// aborts with an error response after TIMEOUT consecutive cycles without progress.
module master_port #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          resetn,
    master_port_if.master bus
);
    localparam int SHIFT_W = ADDR_WIDTH + DATA_WIDTH;
    localparam int BIT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int BIT_W   = $clog2(BIT_MAX + 1);
    localparam int TO_W    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RWAIT, S_DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_mode;
    logic                 r_err;
    logic [SHIFT_W-1:0]   r_shift;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [BIT_W-1:0]     r_bit;
    logic [TO_W-1:0]      r_idle;

    logic w_accept;
    logic w_tx;
    logic w_rx;
    logic w_busy;
    logic w_timeout;
    logic w_last_addr;
    logic w_last_data;

    assign w_accept    = (r_state == S_IDLE) && bus.req_valid;
    assign w_tx        = ((r_state == S_ADDR) || (r_state == S_DATA)) && bus.slave_ready;
    assign w_rx        = (r_state == S_RWAIT) && bus.slave_valid;
    assign w_busy      = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_RWAIT);
    assign w_last_addr = (r_bit == BIT_W'(ADDR_WIDTH - 1));
    assign w_last_data = (r_bit == BIT_W'(DATA_WIDTH - 1));
    // Abort on the cycle that would make the idle count reach TIMEOUT.
    assign w_timeout   = w_busy && !(w_tx || w_rx) && (r_idle == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_err   <= 1'b0;
            r_shift <= '0;
            r_rdata <= '0;
            r_bit   <= '0;
            r_idle  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_mode  <= bus.req_mode;
                r_shift <= {bus.req_addr, (bus.req_mode ? bus.req_wdata : {DATA_WIDTH{1'b0}})};
                r_rdata <= '0;
                r_err   <= 1'b0;
                r_bit   <= '0;
                r_idle  <= '0;
            end else begin
                if (w_tx)
                    r_shift <= {r_shift[SHIFT_W-2:0], 1'b0};
                if (w_rx)
                    r_rdata <= {r_rdata[DATA_WIDTH-2:0], bus.rd_bus};
                if (w_timeout)
                    r_err <= 1'b1;
                if (w_next != r_state) begin
                    r_bit  <= '0;
                    r_idle <= '0;
                end else if (w_tx || w_rx) begin
                    r_bit  <= r_bit + 1'b1;
                    r_idle <= '0;
                end else if (w_busy) begin
                    r_idle <= r_idle + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_next           = r_state;
        bus.req_ready    = 1'b0;
        bus.master_valid = 1'b0;
        bus.master_ready = 1'b0;
        bus.wr_bus       = 1'b0;
        bus.rsp_valid    = 1'b0;
        bus.rsp_err      = 1'b0;
        bus.rsp_rdata    = '0;
        bus.mode         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid)
                    w_next = S_ADDR;
            end
            S_ADDR: begin
                bus.mode         = r_mode;
                bus.master_valid = 1'b1;
                bus.wr_bus       = r_shift[SHIFT_W-1];
                if (w_timeout)
                    w_next = S_DONE;
                else if (w_tx && w_last_addr)
                    w_next = S_DATA;
            end
            S_DATA: begin
                bus.mode         = r_mode;
                bus.master_valid = 1'b1;
                bus.wr_bus       = r_shift[SHIFT_W-1];
                if (w_timeout)
                    w_next = S_DONE;
                else if (w_tx && w_last_data)
                    w_next = r_mode ? S_DONE : S_RWAIT;
            end
            S_RWAIT: begin
                bus.mode         = r_mode;
                bus.master_ready = 1'b1;
                if (w_timeout)
                    w_next = S_DONE;
                else if (w_rx && w_last_data)
                    w_next = S_DONE;
            end
            S_DONE: begin
                bus.mode      = r_mode;
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = r_err;
                bus.rsp_rdata = r_err ? '0 : r_rdata;
                w_next        = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_master_port.sv
// Randomized bench for master_port: a transaction-level model predicts every output
// each cycle, while directed scenarios pin literal expectations.
module tb_master_port;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 255;
    localparam int FR = AW + DW;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    master_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a transaction is a 24-bit frame to send, then (reads) 8 bits to collect.
    bit          m_active, m_resp, m_mode, m_err, m_prog;
    logic [FR-1:0] m_frame;
    logic [DW-1:0] m_rdata;
    int          m_sent, m_recv, m_stall;
    logic        e_mv, e_mr, e_wr;

    always @(negedge clk) begin
        if (!resetn) begin
            m_active = 0; m_resp = 0; m_mode = 0; m_err = 0;
            m_frame = '0; m_rdata = '0; m_sent = 0; m_recv = 0; m_stall = 0;
            chk("rst_master_valid", bus.master_valid, 0);
            chk("rst_master_ready", bus.master_ready, 0);
            chk("rst_wr_bus", bus.wr_bus, 0);
            chk("rst_mode", bus.mode, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
        end else begin
            e_mv = m_active && (m_sent < FR);
            e_mr = m_active && (m_sent == FR);
            e_wr = 1'b0;
            if (e_mv) e_wr = m_frame[FR-1-m_sent];
            chk("req_ready", bus.req_ready, !m_active && !m_resp);
            chk("master_valid", bus.master_valid, e_mv);
            chk("master_ready", bus.master_ready, e_mr);
            chk("wr_bus", bus.wr_bus, e_wr);
            chk("mode", bus.mode, (m_active || m_resp) ? m_mode : 1'b0);
            chk("rsp_valid", bus.rsp_valid, m_resp);
            if (m_resp) begin
                chk("rsp_rdata", bus.rsp_rdata, m_err ? 8'h00 : m_rdata);
                chk("rsp_err", bus.rsp_err, m_err);
            end
            if (m_resp) begin
                m_resp = 0;
            end else if (!m_active) begin
                if (bus.req_valid) begin
                    m_active = 1; m_mode = bus.req_mode; m_err = 0; m_rdata = '0;
                    m_frame = {bus.req_addr, bus.req_mode ? bus.req_wdata : 8'h00};
                    m_sent = 0; m_recv = 0; m_stall = 0;
                end
            end else begin
                m_prog = (m_sent < FR) ? bus.slave_ready : bus.slave_valid;
                if (m_prog) begin
                    m_stall = 0;
                    if (m_sent < FR) begin
                        m_sent++;
                        if (m_sent == FR && m_mode) begin m_active = 0; m_resp = 1; end
                    end else begin
                        m_rdata = {m_rdata[DW-2:0], bus.rd_bus};
                        m_recv++;
                        if (m_recv == DW) begin m_active = 0; m_resp = 1; end
                    end
                end else begin
                    m_stall++;
                    if (m_stall == TO) begin m_active = 0; m_resp = 1; m_err = 1; end
                end
            end
        end
    end

    logic [23:0] t_stream;
    logic [7:0]  t_rdata;
    int          t_nbits, t_rwait, t_rsp, t_mode_bad, t_stalls;
    bit          t_err, t_stall_bit;

    // One transaction from the client and serial-slave side; called at posedge+2.
    task automatic do_txn(input bit wr, input logic [15:0] a, input logic [7:0] d,
                          input logic [7:0] sd, input int rdy_pct, input int vld_pct,
                          input int stall_at, input int rdelay, input bit never_valid,
                          input int reset_at);
        bit seen, accepted, accepting;
        int recv, waited;
        t_stream = '0; t_rdata = '0; t_nbits = 0; t_rwait = 0; t_rsp = 0;
        t_mode_bad = 0; t_stalls = 0; t_err = 0; t_stall_bit = 0;
        seen = 0; accepted = 0; recv = 0; waited = 0;
        bus.req_valid = 1; bus.req_mode = wr; bus.req_addr = a; bus.req_wdata = d;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (reset_at >= 0 && t_nbits == reset_at) begin
                resetn = 0;
                bus.req_valid = 0; bus.slave_ready = 0; bus.slave_valid = 0; bus.rd_bus = 0;
                #1;
                chk("rstmid_master_valid", bus.master_valid, 0);
                chk("rstmid_wr_bus", bus.wr_bus, 0);
                chk("rstmid_mode", bus.mode, 0);
                chk("rstmid_rsp_valid", bus.rsp_valid, 0);
                chk("rstmid_rsp_err", bus.rsp_err, 0);
                chk("rstmid_rsp_rdata", bus.rsp_rdata, 0);
                @(posedge clk); #2;
                resetn = 1;
                return;
            end
            if (bus.rsp_valid) begin
                t_rsp++; seen = 1; t_rdata = bus.rsp_rdata; t_err = bus.rsp_err;
            end else if (seen) begin
                bus.req_valid = 0;
                return;
            end
            accepting = !accepted && bus.req_ready;
            if (bus.master_valid) begin
                if (stall_at >= 0 && t_nbits == stall_at && t_stalls < 5) begin
                    bus.slave_ready = 0;
                    t_stalls++;
                    if (t_stalls == 1) t_stall_bit = bus.wr_bus;
                    else chk("stall_hold", bus.wr_bus, t_stall_bit);
                end else begin
                    bus.slave_ready = ($urandom_range(1, 100) <= rdy_pct);
                end
                if (bus.slave_ready) begin
                    t_stream = {t_stream[22:0], bus.wr_bus};
                    t_nbits++;
                    if (bus.mode !== wr) t_mode_bad++;
                end
            end else begin
                bus.slave_ready = 1'($urandom_range(0, 1));
            end
            bus.rd_bus = 1'($urandom_range(0, 1));
            if (bus.master_ready) begin
                t_rwait++;
                if (never_valid) bus.slave_valid = 0;
                else if (waited < rdelay) begin bus.slave_valid = 0; waited++; end
                else begin
                    bus.slave_valid = ($urandom_range(1, 100) <= vld_pct) && (recv < 8);
                    if (bus.slave_valid) begin bus.rd_bus = sd[7-recv]; recv++; end
                end
            end else begin
                bus.slave_valid = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #2;
            if (accepting) accepted = 1;
            if (accepted) begin
                bus.req_valid = 1'($urandom_range(0, 1));
                bus.req_mode = 1'($urandom_range(0, 1));
                bus.req_addr = 16'($urandom); bus.req_wdata = 8'($urandom);
            end
        end
        n_fail++;
        $display("FAIL txn_budget: no response within 2000 cycles, required a response");
        bus.req_valid = 0;
    endtask

    initial begin
        int acc[$];
        int b2b_rsp;
        logic [15:0] ra;
        logic [7:0] rd, rs;
        bit rw;
        bus.req_valid = 0; bus.req_mode = 0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.rd_bus = 0; bus.slave_ready = 0; bus.slave_valid = 0;
        repeat (3) @(posedge clk);
        #2 resetn = 1;
        #1;
        chk("reset_req_ready", bus.req_ready, 1);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 0);
        chk("reset_rsp_err", bus.rsp_err, 0);
        chk("reset_master_valid", bus.master_valid, 0);

        do_txn(1, 16'h00A5, 8'h3C, 8'h00, 100, 100, -1, 0, 0, -1);
        chk("wr_stream", t_stream, 24'h00A53C);
        chk("wr_nbits", t_nbits, 24);
        chk("wr_rsp_cycles", t_rsp, 1);
        chk("wr_err", t_err, 0);
        chk("wr_mode", t_mode_bad, 0);

        do_txn(0, 16'h0010, 8'hFF, 8'hC3, 100, 100, -1, 3, 0, -1);
        chk("rd_stream", t_stream, 24'h001000);
        chk("rd_rwait_cycles", t_rwait, 11);
        chk("rd_rdata", t_rdata, 8'hC3);
        chk("rd_err", t_err, 0);

        do_txn(1, 16'h0180, 8'h5A, 8'h00, 100, 100, 7, 0, 0, -1);
        chk("stall_stream", t_stream, 24'h01805A);
        chk("stall_nbits", t_nbits, 24);
        chk("stall_count", t_stalls, 5);
        chk("stall_bit", t_stall_bit, 1);

        do_txn(0, 16'h1234, 8'h00, 8'hFF, 100, 100, -1, 0, 1, -1);
        chk("to_rwait_cycles", t_rwait, 255);
        chk("to_err", t_err, 1);
        chk("to_rdata", t_rdata, 8'h00);
        chk("to_rsp_cycles", t_rsp, 1);

        do_txn(1, 16'h0F0F, 8'hAA, 8'h00, 100, 100, -1, 0, 0, 20);
        t_rsp = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.rsp_valid) t_rsp++;
            @(posedge clk); #2;
        end
        chk("rstmid_no_rsp", t_rsp, 0);
        chk("rstmid_idle", bus.req_ready, 1);
        do_txn(1, 16'h7E81, 8'h99, 8'h00, 100, 100, -1, 0, 0, -1);
        chk("post_rst_stream", t_stream, 24'h7E8199);
        chk("post_rst_err", t_err, 0);

        for (int i = 0; i < 40; i++) begin
            rw = 1'($urandom_range(0, 1));
            ra = 16'($urandom); rd = 8'($urandom); rs = 8'($urandom);
            do_txn(rw, ra, rd, rs, $urandom_range(50, 100), $urandom_range(50, 100),
                   -1, $urandom_range(0, 4), 0, -1);
            chk("rnd_stream", t_stream, {ra, rw ? rd : 8'h00});
            chk("rnd_rsp_cycles", t_rsp, 1);
            chk("rnd_rdata", t_rdata, rw ? 8'h00 : rs);
        end

        bus.req_valid = 1; bus.req_mode = 1; bus.slave_ready = 1; bus.slave_valid = 0;
        b2b_rsp = 0;
        for (int c = 0; c < 80; c++) begin
            bus.req_addr = 16'($urandom); bus.req_wdata = 8'($urandom);
            if (bus.req_ready) acc.push_back(c);
            if (bus.rsp_valid) b2b_rsp++;
            @(posedge clk); #2;
        end
        bus.req_valid = 0;
        chk("b2b_accepts", acc.size(), 4);
        chk("b2b_rsp", b2b_rsp, 3);
        if (acc.size() >= 3) begin
            chk("b2b_gap1", acc[1] - acc[0], 26);
            chk("b2b_gap2", acc[2] - acc[1], 26);
        end
        for (int k = 0; k < 200 && !bus.req_ready; k++) begin
            @(posedge clk); #2;
        end
        chk("drain_idle", bus.req_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end
endmodule
